reg_load_sequencer: RTL and testbench

REG_LOAD_SEQUENCER -- requirements
Module: reg_load_sequencer

---
 rtl/reg_seq_pkg.sv | 15 +
 rtl/sync_fifo.sv | 65 ++++++
 rtl/reg_load_sequencer.sv | 124 ++++++++++++
 tb/tb_reg_load_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/reg_seq_pkg.sv
// Shared definitions for the register-load sequencer.
// Contents:
//   seq_state_e : sequencer FSM states (IDLE, LOAD, WAIT).
package reg_seq_pkg;

  // IDLE : nothing in flight; waits for a buffered word.
  // LOAD : en is high for this cycle; data holds the word being loaded.
  // WAIT : enforced idle gap between two loads.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } seq_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO buffer with a registered occupancy count.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   push/wdata : write wdata when push is high and the buffer is not full
//   pop        : drop the head entry when pop is high and the buffer is not empty
//   head       : current head entry (valid only while count != 0)
//   count      : number of stored entries, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  // Guard both sides so occupancy can never overflow or underflow.
  assign do_push = push && (count_q < (AW+1)'(DEPTH));
  assign do_pop  = pop && (count_q != '0);

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  // Storage array; contents need no reset because reads are gated by count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/reg_load_sequencer.sv
// Buffers producer words and replays them to a downstream register as
// one-cycle load strobes, with GAP idle cycles forced between loads.
// Ports:
//   clk, reset         : clock and synchronous active-high reset
//   in_data/in_valid   : producer word and its valid flag
//   in_ready           : word accepted on this edge if in_valid is also high
//   data               : word presented to the downstream register
//   en                 : one-cycle load strobe (high only in LOAD)
//   busy               : buffer non-empty or a load/gap in progress
//   count              : buffered words not yet issued
module reg_load_sequencer
  import reg_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int GAP   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       data,
  output logic                   en,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_INIT = GW'((GAP > 0) ? (GAP - 1) : 0);

  seq_state_e       state_q;
  seq_state_e       state_d;
  logic [GW-1:0]    gap_q;
  logic [GW-1:0]    gap_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] fifo_head;
  logic [CW-1:0]    fifo_count;
  logic             push_s;
  logic             pop_s;
  logic             nonempty_s;

  // No pass-through: a full buffer refuses even if a pop happens this edge.
  assign in_ready   = !reset && (fifo_count < CW'(DEPTH));
  assign push_s     = in_valid && in_ready;
  assign nonempty_s = (fifo_count != '0);

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .wdata (in_data),
    .pop   (pop_s),
    .head  (fifo_head),
    .count (fifo_count)
  );

  assign en    = (state_q == LOAD);
  assign data  = data_q;
  assign count = fifo_count;
  assign busy  = nonempty_s || (state_q != IDLE);

  // Next-state logic; every pop moves the head word into data and enters LOAD.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pop_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (nonempty_s) begin
          pop_s   = 1'b1;
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (GAP > 0) begin
          state_d = WAIT;
          gap_d   = GAP_INIT;
        end else if (nonempty_s) begin
          pop_s   = 1'b1;
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        // Counter runs GAP-1 down to 0, giving exactly GAP cycles in WAIT.
        if (gap_q != '0) begin
          gap_d = gap_q - GW'(1);
        end else if (nonempty_s) begin
          pop_s   = 1'b1;
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, gap counter and output data register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gap_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      if (pop_s) begin
        data_q <= fifo_head;
      end
    end
  end

endmodule

// File: tb/tb_reg_load_sequencer.sv
module tb_reg_load_sequencer;

  localparam int W = 4;
  localparam int D = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] din   [2];
  logic         vld   [2];
  logic         rdy   [2];
  logic [W-1:0] dout  [2];
  logic         en    [2];
  logic         busy  [2];
  logic [2:0]   cnt   [2];

  // Instance 0 uses GAP=2, instance 1 uses GAP=0.
  reg_load_sequencer #(.WIDTH(W), .DEPTH(D), .GAP(2)) dut (
    .clk(clk), .reset(rst), .in_data(din[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
    .data(dout[0]), .en(en[0]), .busy(busy[0]), .count(cnt[0])
  );

  reg_load_sequencer #(.WIDTH(W), .DEPTH(D), .GAP(0)) dut0 (
    .clk(clk), .reset(rst), .in_data(din[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
    .data(dout[1]), .en(en[1]), .busy(busy[1]), .count(cnt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each accepted word is scheduled to be issued at edge
  // max(push_edge+1, previous_issue_edge+GAP+1); words issue in push order.
  int           gap_of   [2];
  int           cyc;
  int           pe       [2][256];
  logic [W-1:0] wd       [2][256];
  int           wr       [2];
  int           rd       [2];
  int           mcnt     [2];
  logic [W-1:0] mdata    [2];
  logic         men      [2];
  int           last_pop [2];
  int           sched    [2];
  logic         accepted [2];
  int           total;
  int           passed;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
  endtask

  task automatic model_edge(input int i);
    logic pushed;
    logic popped;
    int   p;
    if (rst) begin
      wr[i] = 0; rd[i] = 0; mcnt[i] = 0; mdata[i] = '0; men[i] = 1'b0;
      last_pop[i] = -100; sched[i] = -100; accepted[i] = 1'b0;
    end else begin
      pushed = vld[i] && (mcnt[i] < D);
      popped = (rd[i] < wr[i]) && (pe[i][rd[i] % 256] == cyc);
      men[i] = popped;
      accepted[i] = pushed;
      if (popped) begin
        mdata[i] = wd[i][rd[i] % 256];
        rd[i]++;
        last_pop[i] = cyc;
      end
      if (pushed) begin
        p = cyc + 1;
        if (sched[i] + gap_of[i] + 1 > p) p = sched[i] + gap_of[i] + 1;
        pe[i][wr[i] % 256] = p;
        wd[i][wr[i] % 256] = din[i];
        wr[i]++;
        sched[i] = p;
      end
      mcnt[i] = mcnt[i] + (pushed ? 1 : 0) - (popped ? 1 : 0);
    end
  endtask

  task automatic check_outputs(input int i);
    string s;
    s = (i == 0) ? "g2" : "g0";
    check({s, "_en"},    32'(en[i]),   32'(men[i]));
    check({s, "_data"},  32'(dout[i]), 32'(mdata[i]));
    check({s, "_count"}, 32'(cnt[i]),  32'(mcnt[i]));
    check({s, "_ready"}, 32'(rdy[i]),  32'(!rst && (mcnt[i] < D)));
    check({s, "_busy"},  32'(busy[i]),
          32'((mcnt[i] != 0) || (cyc - last_pop[i] <= gap_of[i])));
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge(0);
    model_edge(1);
    #1;
    check_outputs(0);
    check_outputs(1);
  endtask

  task automatic idle(input int n);
    vld[0] = 1'b0;
    vld[1] = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic push_one(input int i, input logic [W-1:0] w);
    din[i] = w;
    vld[i] = 1'b1;
    tick();
    vld[i] = 1'b0;
  endtask

  initial begin
    logic [W-1:0] words [6];
    int k;
    int guard;
    gap_of[0] = 2; gap_of[1] = 0;
    total = 0; passed = 0; cyc = 0;
    for (int i = 0; i < 2; i++) begin
      din[i] = '0; vld[i] = 1'b0;
      wr[i] = 0; rd[i] = 0; mcnt[i] = 0; mdata[i] = '0; men[i] = 1'b0;
      last_pop[i] = -100; sched[i] = -100; accepted[i] = 1'b0;
    end

    // Reset, with a word offered that must be dropped.
    rst = 1'b1;
    vld[0] = 1'b1; din[0] = 4'b0111;
    tick();
    tick();
    rst = 1'b0;
    idle(3);

    // Single word: one strobe with data 1010, then idle.
    push_one(0, 4'b1010);
    idle(6);

    // Four words back to back through the GAP=2 instance.
    for (int j = 1; j <= 4; j++) push_one(0, W'(j));
    idle(15);

    // Six words with in_valid held; word advances only when accepted.
    words[0] = 4'h5; words[1] = 4'h9; words[2] = 4'hE;
    words[3] = 4'h3; words[4] = 4'h8; words[5] = 4'hC;
    k = 0; guard = 0;
    vld[0] = 1'b1;
    while (k < 6 && guard < 100) begin
      din[0] = words[k];
      tick();
      if (accepted[0]) k++;
      guard++;
    end
    vld[0] = 1'b0;
    check("six_words_accepted", 32'(k), 32'd6);
    idle(20);

    // GAP=0: three consecutive words give three consecutive strobes.
    push_one(1, 4'b1100);
    push_one(1, 4'b0110);
    push_one(1, 4'b1111);
    idle(6);

    // Reset while count=3 and the FSM sits in WAIT, then resume.
    for (int j = 0; j < 4; j++) push_one(0, W'(4'h6 + j));
    check("pre_reset_count", 32'(cnt[0]), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push_one(0, 4'b0011);
    idle(6);

    // Randomized traffic on both instances with occasional resets.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < 2; i++) begin
        vld[i] = ($urandom_range(0, 2) != 0);
        din[i] = W'($urandom);
      end
      tick();
    end
    rst = 1'b0;
    idle(25);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
